pbuf_serial_port: RTL and testbench
===================================

// Module: pbuf_serial_port
// PURPOSE
//  Pattern-buffer side of the debug serial link. Consumes sclk/ssel/sin/saddr (one of the _low/_high
//  sets steered by the pad ring) and returns sout.
//  Lets the host read and write a bank of 7 config registers that drive the pattern buffer, plus one
//  read-only status register.
//  The serial pins are asynchronous to clk_int. They are synchronised, edge-detected and framed
//  here, entirely in the clk_int domain.
// PARAMETERS
//  d_width      8   register and data width in bits
//  sync_stages  2   flops in each input synchroniser (>=2)
// PORTS
//  clk_int      in   1            core clock; all logic is on its rising edge
//  reset        in   1            asynchronous, active-low reset
//  sclk         in   1            serial clock from pads (async)
//  ssel         in   1            frame select, active high (async)
//  sin          in   1            serial data in (async)
//  saddr        in   3            register address; sampled at frame start
//  status_in    in   d_width      value read from address 7
//  sout         out  1            serial data out to pads
//  cfg_regs     out  7*d_width    regs 0..6, reg n at [n*d_width +: d_width]
//  wr_strobe    out  1            one-cycle pulse when a register is written
//  wr_addr      out  3            address of the last write; valid with wr_strobe
//  frame_err    out  1            sticky flag; cleared at the start of the next frame
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, all registers 0, FSM=IDLE, synchronisers cleared.
//  Sync: sclk, ssel and sin each pass through sync_stages flops. Edges are detected on the
//   synchronised sclk/ssel against a 1-cycle-delayed copy.
//   - Edge is flagged sync_stages+1 cycles after the pin changes.
//   - sin is sampled from its synchronised copy in the same cycle the sclk rise is flagged.
//  Host timing: sclk high/low and ssel setup/hold >= sync_stages+2 clk_int cycles.
//  Frame: d_width+1 bits, MSB first. Bit0 = rw flag (1=write, 0=read); then d_width data bits.
//  FSM states: IDLE, RWBIT, SHIFT, DONE.
//   IDLE->RWBIT on ssel rise:
//    - latch saddr into addr_q
//    - load data_sr (d_width) with cfg_regs[addr_q], or with status_in if addr_q=7
//    - bit_cnt=0, frame_err=0
//   RWBIT->SHIFT on first sclk rise: rw_q=sin; data_sr is not shifted.
//   SHIFT: each sclk rise does data_sr <= {data_sr[d_width-2:0], sin} and bit_cnt++.
//    bit_cnt saturates at d_width+1.
//   Any state except IDLE -> DONE on ssel fall. DONE -> IDLE always, after 1 cycle.
//  Outcome in DONE:
//   - bit_cnt==d_width, rw_q=1, addr_q<7: write data_sr to register addr_q.
//     cfg_regs updates on the cycle after DONE; wr_strobe=1 and wr_addr=addr_q in that same cycle.
//   - bit_cnt==d_width, rw_q=0: read; no write, no error.
//   - Aborted, no error: ssel fall in RWBIT with no sclk edge seen.
//   - Error (frame_err=1, no write): bit_cnt!=d_width after the rw bit was taken; or a write to addr 7.
//  sout:
//   - registered; equals data_sr[d_width-1] while FSM != IDLE, else 0
//   - updates 1 cycle after the load or shift that changes data_sr
//  Boundary cases:
//   - sclk rise in the same cycle as ssel fall: the ssel fall wins; that bit is ignored.
//   - sclk edges while ssel is low are ignored.
//   - ssel rise while in DONE: taken on the next cycle; the synchronised level is still high.
//   - reset mid-frame: frame abandoned, no write, registers return to 0.
//  saddr and status_in are sampled only at frame start; later changes do not affect the frame.
// TESTING
//  1 Write: frame rw=1, addr=3, data 0xA5 -> cfg_regs[31:24]=0xA5; one wr_strobe, wr_addr=3;
//    frame_err=0.
//  2 Readback: after test 1, read frame addr=3 -> sout bits across the 8 data clocks = 1,0,1,0,0,1,0,1;
//    cfg unchanged; no strobe.
//  3 Status: status_in=0x3C, read addr 7 -> sout returns 0x3C; write addr 7 -> frame_err=1,
//    no strobe.
//  4 Length errors: 5 data bits, rw=1, addr 2 -> frame_err=1, reg 2 unchanged.
//    10 data bits -> frame_err=1. Next good frame clears frame_err.
//  5 Reset: reset=0 at data bit 4 of a write to addr 1 -> all outputs 0 immediately.
//    After release, a full write works.
//  6 Timing: sclk half-period exactly sync_stages+2 cycles, random data to all 7 regs
//    -> every readback matches; sclk edges with ssel=0 cause no state change.

Source files
------------

// File: rtl/pbuf_serial_port.sv
// Debug serial link slave for the pattern buffer: 7 read/write config registers plus a read-only
// status register. The serial pins are synchronised and framed entirely in the clk_int domain.
//
//  state | meaning
//  IDLE  | no frame; waiting for the synchronised ssel to go high
//  RWBIT | frame open, address latched, waiting for the rw bit on the first sclk rise
//  SHIFT | shifting data bits (MSB first) in on sin and out on sout
//  DONE  | frame closed; commit the write or raise frame_err, then back to IDLE
module pbuf_serial_port #(
    parameter int d_width     = 8,
    parameter int sync_stages = 2
) (
    input  logic                   clk_int,
    input  logic                   reset,
    input  logic                   sclk,
    input  logic                   ssel,
    input  logic                   sin,
    input  logic [2:0]             saddr,
    input  logic [d_width-1:0]     status_in,
    output logic                   sout,
    output logic [7*d_width-1:0]   cfg_regs,
    output logic                   wr_strobe,
    output logic [2:0]             wr_addr,
    output logic                   frame_err
);

    localparam int cnt_w = $clog2(d_width + 2);

    typedef enum logic [1:0] {IDLE, RWBIT, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [sync_stages-1:0] sclk_sync, ssel_sync, sin_sync;
    logic                 sclk_d, ssel_d;
    logic                 sclk_s, ssel_s, sin_s;
    logic                 sclk_rise, ssel_fall;

    logic [2:0]           addr_q, addr_nxt;
    logic [d_width-1:0]   data_sr, data_nxt;
    logic [cnt_w-1:0]     bit_cnt, cnt_nxt;
    logic                 rw_q, rw_nxt;
    logic                 rw_seen, rw_seen_nxt;
    logic                 err_nxt;
    logic                 cfg_we;
    logic [2:0]           wr_addr_nxt;
    logic [d_width-1:0]   load_val;
    logic [d_width-1:0]   cfg_q [7];

    assign sclk_s    = sclk_sync[sync_stages-1];
    assign ssel_s    = ssel_sync[sync_stages-1];
    assign sin_s     = sin_sync[sync_stages-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ssel_fall = ~ssel_s & ssel_d;

    for (genvar g = 0; g < 7; g++) begin : g_cfg_out
        assign cfg_regs[g*d_width +: d_width] = cfg_q[g];
    end

    always_comb begin
        load_val = status_in;
        for (int i = 0; i < 7; i++) begin
            if (saddr == 3'(i)) load_val = cfg_q[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        data_nxt    = data_sr;
        cnt_nxt     = bit_cnt;
        rw_nxt      = rw_q;
        rw_seen_nxt = rw_seen;
        err_nxt     = frame_err;
        cfg_we      = 1'b0;
        wr_addr_nxt = wr_addr;
        unique case (state)
            IDLE: begin
                // Level, not edge: a rise that landed during DONE is still honoured here.
                if (ssel_s) begin
                    state_nxt   = RWBIT;
                    addr_nxt    = saddr;
                    data_nxt    = load_val;
                    cnt_nxt     = '0;
                    err_nxt     = 1'b0;
                    rw_seen_nxt = 1'b0;
                end
            end
            RWBIT: begin
                if (ssel_fall) begin
                    state_nxt = DONE;
                end else if (sclk_rise) begin
                    rw_nxt      = sin_s;
                    rw_seen_nxt = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (ssel_fall) begin
                    state_nxt = DONE;
                end else if (sclk_rise) begin
                    data_nxt = {data_sr[d_width-2:0], sin_s};
                    if (bit_cnt != cnt_w'(d_width + 1)) cnt_nxt = bit_cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (rw_seen) begin
                    if (bit_cnt != cnt_w'(d_width)) begin
                        err_nxt = 1'b1;
                    end else if (rw_q) begin
                        if (addr_q == 3'd7) begin
                            err_nxt = 1'b1;
                        end else begin
                            cfg_we      = 1'b1;
                            wr_addr_nxt = addr_q;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_int or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            ssel_sync <= '0;
            sin_sync  <= '0;
            sclk_d    <= 1'b0;
            ssel_d    <= 1'b0;
            state     <= IDLE;
            addr_q    <= '0;
            data_sr   <= '0;
            bit_cnt   <= '0;
            rw_q      <= 1'b0;
            rw_seen   <= 1'b0;
            frame_err <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            sout      <= 1'b0;
            for (int i = 0; i < 7; i++) cfg_q[i] <= '0;
        end else begin
            sclk_sync <= {sclk_sync[sync_stages-2:0], sclk};
            ssel_sync <= {ssel_sync[sync_stages-2:0], ssel};
            sin_sync  <= {sin_sync[sync_stages-2:0], sin};
            sclk_d    <= sclk_s;
            ssel_d    <= ssel_s;
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            data_sr   <= data_nxt;
            bit_cnt   <= cnt_nxt;
            rw_q      <= rw_nxt;
            rw_seen   <= rw_seen_nxt;
            frame_err <= err_nxt;
            wr_strobe <= cfg_we;
            wr_addr   <= wr_addr_nxt;
            sout      <= (state != IDLE) ? data_sr[d_width-1] : 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (cfg_we && addr_q == 3'(i)) cfg_q[i] <= data_sr;
            end
        end
    end

endmodule

// File: tb/tb_pbuf_serial_port.sv
// Randomised frame-level bench for pbuf_serial_port, checked against a register-array model.
module tb_pbuf_serial_port;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk_int = 1'b0;
    logic          reset = 1'b0;
    logic          sclk = 1'b0;
    logic          ssel = 1'b0;
    logic          sin = 1'b0;
    logic [2:0]    saddr = '0;
    logic [DW-1:0] status_in = '0;
    logic          sout;
    logic [7*DW-1:0] cfg_regs;
    logic          wr_strobe;
    logic [2:0]    wr_addr;
    logic          frame_err;

    pbuf_serial_port #(.d_width(DW), .sync_stages(SS)) dut (
        .clk_int(clk_int), .reset(reset), .sclk(sclk), .ssel(ssel), .sin(sin),
        .saddr(saddr), .status_in(status_in), .sout(sout), .cfg_regs(cfg_regs),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk_int = ~clk_int;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] model_regs [7];
    bit            mon_en = 0;
    int            strobe_cnt = 0;
    logic [2:0]    last_wr_addr = '0;
    int            half = SS + 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7*DW-1:0] model_packed();
        logic [7*DW-1:0] v;
        for (int i = 0; i < 7; i++) v[i*DW +: DW] = model_regs[i];
        return v;
    endfunction

    always @(negedge clk_int) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            last_wr_addr = wr_addr;
        end
        if (mon_en) check("cfg_regs", cfg_regs, model_packed());
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_int);
        #1;
    endtask

    // ndata < 0: ssel pulse with no sclk at all. reset_at >= 0: pull reset before that data bit.
    task automatic run_frame(input logic [2:0] a, input logic rw, input logic [15:0] data,
                             input int ndata, input int reset_at, output logic [DW-1:0] got);
        logic [DW-1:0] init;
        int            s0;
        int            nclk;
        bit            taken, exp_err, exp_wr;
        init  = (a == 3'd7) ? status_in : model_regs[a];
        s0    = strobe_cnt;
        nclk  = (ndata < 0) ? 0 : ndata + 1;
        got   = '0;
        saddr = a;
        ssel  = 1'b1;
        cyc(half);
        check("frame_err_cleared", frame_err, 1'b0);
        saddr     = 3'($urandom);
        status_in = DW'($urandom);
        for (int j = 0; j < nclk; j++) begin
            sin = (j == 0) ? rw : data[ndata - j];
            cyc(half);
            if (j >= 1 && j - 1 == reset_at) begin
                mon_en = 0;
                reset  = 1'b0;
                #1;
                check("rst_sout", sout, 1'b0);
                check("rst_cfg", cfg_regs, '0);
                check("rst_strobe", wr_strobe, 1'b0);
                check("rst_wr_addr", wr_addr, 3'd0);
                check("rst_frame_err", frame_err, 1'b0);
                for (int i = 0; i < 7; i++) model_regs[i] = '0;
                sclk = 1'b0;
                ssel = 1'b0;
                cyc(3);
                reset = 1'b1;
                cyc(2 * half);
                mon_en = 1;
                return;
            end
            if (j >= 1 && j - 1 < DW) begin
                got[DW - j] = sout;
                check("sout_bit", sout, init[DW - j]);
            end
            sclk = 1'b1;
            cyc(half);
            sclk = 1'b0;
        end
        cyc(half);
        mon_en = 0;
        ssel   = 1'b0;
        cyc(3 * half);
        taken   = (ndata >= 0);
        exp_err = taken && (ndata != DW || (rw && a == 3'd7));
        exp_wr  = (ndata == DW) && rw && (a != 3'd7);
        check("frame_err", frame_err, exp_err);
        check("strobe_count", strobe_cnt - s0, exp_wr ? 1 : 0);
        if (exp_wr) begin
            check("wr_addr", last_wr_addr, a);
            model_regs[a] = data[DW-1:0];
        end
        check("sout_idle", sout, 1'b0);
        mon_en = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] got;
        logic          err_save;
        int            s0;
        for (int i = 0; i < 7; i++) model_regs[i] = '0;

        cyc(3);
        check("reset_sout", sout, 1'b0);
        check("reset_cfg", cfg_regs, '0);
        check("reset_strobe", wr_strobe, 1'b0);
        check("reset_wr_addr", wr_addr, 3'd0);
        check("reset_err", frame_err, 1'b0);
        reset = 1'b1;
        cyc(2);
        mon_en = 1;

        // write / readback
        run_frame(3'd3, 1'b1, 16'h00A5, 8, -1, got);
        check("t1_reg3", cfg_regs[31:24], 8'hA5);
        check("t1_err", frame_err, 1'b0);
        run_frame(3'd3, 1'b0, 16'h0000, 8, -1, got);
        check("t2_readback", got, 8'hA5);

        // status register
        status_in = 8'h3C;
        run_frame(3'd7, 1'b0, 16'h0000, 8, -1, got);
        check("t3_status", got, 8'h3C);
        run_frame(3'd7, 1'b1, 16'h0055, 8, -1, got);
        check("t3_wr7_err", frame_err, 1'b1);

        // length errors, abort, and recovery
        run_frame(3'd2, 1'b1, 16'h001B, 5, -1, got);
        check("t4_reg2", cfg_regs[23:16], 8'h00);
        run_frame(3'd2, 1'b1, 16'h02AB, 10, -1, got);
        run_frame(3'd4, 1'b1, 16'h0077, 8, -1, got);
        check("t4_recover", frame_err, 1'b0);
        run_frame(3'd5, 1'b1, 16'h0000, -1, -1, got);
        run_frame(3'd5, 1'b1, 16'h0000, 0, -1, got);

        // reset mid-frame, then a full write
        run_frame(3'd1, 1'b1, 16'h00C3, 8, 4, got);
        run_frame(3'd1, 1'b1, 16'h003E, 8, -1, got);
        check("t5_reg1", cfg_regs[15:8], 8'h3E);

        // minimum host timing: random write/readback of every register
        half = SS + 2;
        for (int a = 0; a < 7; a++) run_frame(3'(a), 1'b1, 16'($urandom), 8, -1, got);
        for (int a = 0; a < 7; a++) begin
            run_frame(3'(a), 1'b0, 16'($urandom), 8, -1, got);
            check("t6_readback", got, model_regs[a]);
        end

        for (int k = 0; k < 20; k++) begin
            int nd;
            nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : DW;
            run_frame(3'($urandom), 1'($urandom), 16'($urandom), nd, -1, got);
        end

        // sclk activity with ssel low must do nothing
        err_save = frame_err;
        s0 = strobe_cnt;
        for (int k = 0; k < 6; k++) begin
            sin  = 1'($urandom);
            sclk = 1'b1;
            cyc(half);
            sclk = 1'b0;
            cyc(half);
        end
        check("idle_sclk_err", frame_err, err_save);
        check("idle_sclk_strobe", strobe_cnt - s0, 0);
        check("idle_sclk_sout", sout, 1'b0);

        mon_en = 0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
